cdc_handshake_rx: RTL and testbench

- Destination-side receiver of a toggle-based request/acknowledge CDC handshake. Sits directly downstream of data_sync_synth, which delivers the synchronised request toggle.
- On each detected request toggle it captures the quasi-static source data bus and presents it on a valid/ready interface.
- Once the word is consumed it returns an acknowledge toggle, which goes back to the source domain through another data_sync_synth.

---
 rtl/cdc_handshake_rx.sv | 86 ++++++++
 tb/tb_cdc_handshake_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_rx.sv
// Destination-side receiver of a toggle request/acknowledge CDC handshake.
// Captures the quasi-static source word on each request toggle and returns an ack toggle.
module cdc_handshake_rx #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter logic        SYNC_RESET_VALUE = 1'b0,
  parameter int unsigned CNT_WIDTH        = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_tgl_sync,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  ack_tgl,
  output logic                  rx_busy,
  output logic                  proto_err,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]            r_state;
  logic                  r_req_prev;
  logic                  r_ack;
  logic                  r_valid;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_WIDTH-1:0]  r_count;

  logic w_req_event;
  logic w_accept;

  assign w_req_event = (req_tgl_sync != r_req_prev);
  assign w_accept    = (r_state == ST_VALID) && out_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_req_prev <= SYNC_RESET_VALUE;
      r_ack      <= SYNC_RESET_VALUE;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_data     <= '0;
      r_count    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_event) begin
            r_data     <= src_data;
            r_req_prev <= req_tgl_sync;
            r_valid    <= 1'b1;
            r_state    <= ST_VALID;
          end
        end
        ST_VALID: begin
          // Source toggled again before seeing our ack; the held word is kept.
          if (w_req_event) begin
            r_err <= 1'b1;
          end
          if (w_accept) begin
            r_valid <= 1'b0;
            r_ack   <= ~r_ack;
            r_count <= r_count + CNT_ONE;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = r_valid;
  assign out_data   = r_data;
  assign ack_tgl    = r_ack;
  assign rx_busy    = (r_state == ST_VALID);
  assign proto_err  = r_err;
  assign xfer_count = r_count;

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Self-checking bench for cdc_handshake_rx: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_cdc_handshake_rx;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_tgl_sync;
  logic [31:0] src_data;
  logic        out_ready;

  logic        out_valid, ack_tgl, rx_busy, proto_err;
  logic [31:0] out_data;
  logic [15:0] xfer_count;

  logic        w_out_valid, w_ack_tgl, w_rx_busy, w_proto_err;
  logic [31:0] w_out_data;
  logic [1:0]  w_xfer_count;

  int total = 0;
  int bad   = 0;

  // Reference model: a held word (or none), the last request level taken, and tallies.
  bit          m_held;
  logic [31:0] m_word;
  bit          m_last_req;
  bit          m_ack;
  bit          m_err;
  int          m_done;

  always #5 clock = ~clock;

  cdc_handshake_rx dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_tgl_sync (req_tgl_sync),
    .src_data     (src_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .ack_tgl      (ack_tgl),
    .rx_busy      (rx_busy),
    .proto_err    (proto_err),
    .xfer_count   (xfer_count)
  );

  cdc_handshake_rx #(.CNT_WIDTH(2)) dut_wrap (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_tgl_sync (req_tgl_sync),
    .src_data     (src_data),
    .out_valid    (w_out_valid),
    .out_ready    (out_ready),
    .out_data     (w_out_data),
    .ack_tgl      (w_ack_tgl),
    .rx_busy      (w_rx_busy),
    .proto_err    (w_proto_err),
    .xfer_count   (w_xfer_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst_n, input bit req, input logic [31:0] data,
                            input bit rdy);
    if (!rst_n) begin
      m_held = 0; m_word = '0; m_last_req = 0; m_ack = 0; m_err = 0; m_done = 0;
    end else if (!m_held) begin
      if (req != m_last_req) begin
        m_held = 1; m_word = data; m_last_req = req;
      end
    end else begin
      if (req != m_last_req) m_err = 1;
      if (rdy) begin
        m_held = 0; m_ack = ~m_ack; m_done++;
      end
    end
  endtask

  // One clock: inputs already applied are sampled at the edge, outputs compared 1ns later.
  task automatic tick();
    bit          s_rst = reset_n;
    bit          s_req = req_tgl_sync;
    logic [31:0] s_dat = src_data;
    bit          s_rdy = out_ready;
    @(posedge clock);
    model_edge(s_rst, s_req, s_dat, s_rdy);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_held});
    check("rx_busy", {31'd0, rx_busy}, {31'd0, m_held});
    check("out_data", out_data, m_word);
    check("ack_tgl", {31'd0, ack_tgl}, {31'd0, m_ack});
    check("proto_err", {31'd0, proto_err}, {31'd0, m_err});
    check("xfer_count", {16'd0, xfer_count}, m_done % 65536);
    check("wrap_count", {30'd0, w_xfer_count}, m_done % 4);
    check("wrap_valid", {31'd0, w_out_valid}, {31'd0, m_held});
  endtask

  int n_valid;

  initial begin
    reset_n = 0; req_tgl_sync = 0; src_data = '0; out_ready = 0;
    repeat (3) tick();
    reset_n = 1;
    repeat (3) tick();
    check("rst_no_capture", {31'd0, out_valid}, 32'd0);
    check("rst_count", {16'd0, xfer_count}, 32'd0);

    // Single transfer with out_ready already high.
    src_data = 32'hDEADBEEF; req_tgl_sync = 1; out_ready = 1;
    tick();
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_data", out_data, 32'hDEADBEEF);
    tick();
    check("single_ack", {31'd0, ack_tgl}, 32'd1);
    check("single_count", {16'd0, xfer_count}, 32'd1);

    // Back-pressure: source data wiggles during the hold but the held word must not.
    src_data = 32'h12345678; req_tgl_sync = 0; out_ready = 0;
    n_valid = 0;
    tick();
    if (out_valid) n_valid++;
    for (int i = 0; i < 10; i++) begin
      src_data = $urandom;
      tick();
      if (out_valid) n_valid++;
      check("bp_ack_hold", {31'd0, ack_tgl}, 32'd1);
    end
    check("bp_data", out_data, 32'h12345678);
    out_ready = 1;
    tick();
    check("bp_valid_cycles", n_valid, 32'd11);
    check("bp_ack", {31'd0, ack_tgl}, 32'd0);

    // Back-to-back: each toggle lands the cycle right after the return to IDLE.
    for (int w = 1; w <= 4; w++) begin
      src_data = w; req_tgl_sync = ~req_tgl_sync;
      tick();
      check("b2b_data", out_data, w);
      tick();
    end
    check("b2b_ack", {31'd0, ack_tgl}, 32'd0);
    check("b2b_count", {16'd0, xfer_count}, 32'd6);

    // Protocol error: second toggle while the first word is still held.
    src_data = 32'hAAAA5555; req_tgl_sync = 1; out_ready = 0;
    tick();
    src_data = 32'h0000BBBB; req_tgl_sync = 0;
    tick();
    check("perr_flag", {31'd0, proto_err}, 32'd1);
    check("perr_data", out_data, 32'hAAAA5555);
    repeat (3) tick();
    out_ready = 1;
    tick();
    tick();
    check("perr_pending_capture", out_data, 32'h0000BBBB);
    tick();
    check("perr_sticky", {31'd0, proto_err}, 32'd1);

    // Reset while a word is held.
    src_data = 32'hCAFEF00D; req_tgl_sync = 1; out_ready = 0;
    tick();
    req_tgl_sync = 0; reset_n = 0;
    tick();
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_ack", {31'd0, ack_tgl}, 32'd0);
    reset_n = 1; out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      src_data = $urandom; req_tgl_sync = ~req_tgl_sync;
      tick();
      tick();
    end
    check("wrap_5", {30'd0, w_xfer_count}, 32'd1);
    check("full_5", {16'd0, xfer_count}, 32'd5);

    // Random traffic: mostly protocol-abiding source, occasional early toggles.
    reset_n = 0; req_tgl_sync = 0;
    tick();
    reset_n = 1;
    for (int c = 0; c < 600; c++) begin
      out_ready = $urandom_range(0, 1);
      if ((req_tgl_sync == ack_tgl && $urandom_range(0, 2) == 0) || $urandom_range(0, 60) == 0) begin
        src_data = $urandom;
        req_tgl_sync = ~req_tgl_sync;
      end
      if ($urandom_range(0, 200) == 0) reset_n = 0;
      else reset_n = 1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
